// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute phases and
// decodes op/funct into datapath enables and ALU control.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t st, st_next;
    logic   pcwrite, branch;

    function automatic logic rtype_ok(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: rtype_ok = 1'b1;
            default:                                               rtype_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_alu = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) st <= FETCH;
        else       st <= st_next;
    end

    // Next-state and per-state datapath controls; strobes masked during reset.
    always_comb begin
        st_next    = FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        PCSrc      = 2'b00;
        illegal    = 1'b0;
        case (st)
            FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                pcwrite = mem_ready;
                st_next = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW: st_next = MEMADR;
                    OP_RTYPE: begin
                        if (rtype_ok(funct)) st_next = EXECUTE;
                        else                 illegal = 1'b1;
                    end
                    OP_BEQ:  st_next = BRANCH;
                    OP_ADDI: st_next = ADDIEX;
                    OP_J:    st_next = JUMP;
                    default: illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                st_next = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD    = 1'b1;
                st_next = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                st_next  = mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu(funct);
                st_next    = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                branch     = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                st_next = ADDIWB;
            end
            ADDIWB: RegWrite = 1'b1;
            JUMP: begin
                PCSrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: st_next = FETCH;
        endcase
        PCEn = pcwrite | (branch & zero);
        if (reset) begin
            PCEn     = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state = 4'(st);

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control FSM for the MIPS core. It sequences the shared 32-bit ALU, register file, PC and unified memory over several cycles per instruction, decoding `op`/`funct` into per-state datapath enables and a 3-bit `ALUControl`. It sits beside the datapath, consumes the ALU `zero` flag and a memory-ready handshake, and drives every write enable in the core.

## Interface
- No parameters. Widths are fixed by the ISA.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: instruction[31:26], valid from DECODE onward (IR held).
- `funct` in 6: instruction[5:0].
- `zero` in 1: ALU zero flag, combinational from the datapath.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCEn` out 1: PC register load; equals `PCWrite | (Branch & zero)`.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: memory write strobe.
- `IRWrite` out 1: instruction register load.
- `RegDst` out 1: destination register select; 0 = rt, 1 = rd.
- `MemtoReg` out 1: write-back select; 0 = ALUOut, 1 = Data.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: ALU A select; 0 = PC, 1 = A.
- `ALUSrcB` out 2: ALU B select; 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUControl` out 3: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `PCSrc` out 2: PC source; 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `illegal` out 1: one-cycle pulse on an unsupported instruction.
- `state` out 4: current state, for debug and coverage.

## Operation
- States and encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXECUTE = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11
  - Encodings 12–15 go to FETCH on the next edge with all outputs at default.
- Default for every output is 0, except `ALUControl` = 010. Each state overrides only the outputs listed below.
- FETCH:
  - IorD=0, SrcA=0, SrcB=01, ADD, PCSrc=00.
  - IRWrite = PCWrite = `mem_ready`.
  - Stay in FETCH while `!mem_ready`; go to DECODE on `mem_ready`.
- DECODE:
  - SrcA=0, SrcB=11, ADD (precomputes the branch target).
  - Next state by `op`:
    - 100011 or 101011 → MEMADR
    - 000000 → EXECUTE
    - 000100 → BRANCH
    - 001000 → ADDIEX
    - 000010 → JUMP
  - Any other `op`, or `op` = 000000 with `funct` not in {100000, 100010, 100100, 100101, 101010}: `illegal` = 1, next state FETCH. The PC has already advanced, so the instruction behaves as a NOP.
- MEMADR: SrcA=1, SrcB=10, ADD. Next is MEMRD if `op` = 100011, else MEMWR.
- MEMRD: IorD=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Go to FETCH.
- MEMWR: IorD=1, MemWrite=1 held every cycle in the state. Go to FETCH on the cycle `mem_ready` = 1.
- EXECUTE: SrcA=1, SrcB=00, ALUControl from `funct`:
  - 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
  - Go to ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Go to FETCH.
- BRANCH: SrcA=1, SrcB=00, SUB, PCSrc=01, Branch=1. Go to FETCH.
- ADDIEX: SrcA=1, SrcB=10, ADD. Go to ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Go to FETCH.
- JUMP: PCSrc=10, PCWrite=1. Go to FETCH.

## Timing
- Outputs are Moore-decoded from the state register. Exceptions:
  - `PCEn` and `IRWrite` in FETCH combine `mem_ready`.
  - `PCEn` in BRANCH combines `zero`.
  - `illegal` in DECODE combines `op`/`funct`.
- Reset: while `reset` is high, force `PCEn`, `IRWrite`, `MemWrite`, `RegWrite` and `illegal` to 0. On the first edge with `reset` high, `state` ← FETCH; all outputs then take FETCH values once `reset` falls.
- Reset mid-instruction, including mid-MEMWR or mid-wait: abandon the instruction, return to FETCH, and issue no further write strobes.
- Latency with `mem_ready` tied high:

  | Instruction | Cycles |
  |---|---|
  | lw | 5 |
  | sw, R-type, addi | 4 |
  | beq, j | 3 |
  | illegal | 2 |

  Each low cycle of `mem_ready` in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR, and is ignored in every other state.
- Back-to-back instructions: FETCH follows the final state with no bubble.

## Test plan
- Reset, then `mem_ready` = 1 with `op` = 100011:
  - `state` runs 0,1,2,3,4,0.
  - RegWrite=1, MemtoReg=1 only in state 4.
  - PCEn=1 only in the first cycle.
- R-type `funct` = 101010:
  - ALUControl = 111 in EXECUTE.
  - RegWrite=1, RegDst=1 in ALUWB.
  - 4 cycles total.
- beq with `zero` = 1 and then `zero` = 0:
  - PCEn=1 with PCSrc=01 in BRANCH for the first case.
  - PCEn=0 in BRANCH for the second.
  - 3 cycles each.
- sw with `mem_ready` low for 3 cycles in MEMWR:
  - MemWrite=1 for 4 consecutive cycles.
  - FETCH follows the cycle where `mem_ready` = 1.
  - Repeat the sequence with `mem_ready` low for 2 cycles in FETCH; IRWrite stays 0 until `mem_ready` = 1.
- `op` = 111111, then `op` = 000000 with `funct` = 000111:
  - `illegal` = 1 in DECODE for one cycle.
  - Return to FETCH, with no RegWrite or MemWrite.
- Assert `reset` during MEMWR and during ADDIWB:
  - MemWrite and RegWrite are 0 in the reset cycle.
  - `state` = 0 on the next cycle.
  - j then executes normally, with PCSrc=10 and PCEn=1 in JUMP.
